// File: rtl/conv55_pkg.sv
// Shared constants and FSM state type for the 5x5 convolution MAC scheduler.
package conv55_pkg;

    localparam int TAPS    = 25;
    localparam int DW      = 8;
    localparam int PW      = 16;
    localparam int AW      = 21;
    localparam int OW      = 18;
    localparam int SAT_MAX = 262143;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KLOAD = 2'd1,
        ACC   = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/conv55_mac_sched_if.sv
// Kernel-load, pixel and result handshakes of the convolution MAC scheduler.
interface conv55_mac_sched_if
    import conv55_pkg::*;
#(
    parameter int DW = conv55_pkg::DW,
    parameter int OW = conv55_pkg::OW
);
    logic          kload_valid;
    logic [DW-1:0] kload_data;
    logic          kload_ready;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_sat;
    logic          out_ready;
    logic          kernel_ok;

    modport master (
        output kload_valid, kload_data, pix_valid, pix_data, out_ready,
        input  kload_ready, pix_ready, out_valid, out_data, out_sat,
        input  kernel_ok
    );

    modport slave (
        input  kload_valid, kload_data, pix_valid, pix_data, out_ready,
        output kload_ready, pix_ready, out_valid, out_data, out_sat,
        output kernel_ok
    );
endinterface

// File: rtl/conv55_mul8u.sv
// Single shared unsigned byte multiplier, exact product.
module conv55_mul8u
    import conv55_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [PW-1:0] p
);
    assign p = PW'(a) * PW'(b);
endmodule

// File: rtl/conv55_mac_sched.sv
// Time-shared 25-tap multiply-accumulate with kernel register file.
module conv55_mac_sched
    import conv55_pkg::*;
#(
    parameter int TAPS = conv55_pkg::TAPS,
    parameter int DW   = conv55_pkg::DW,
    parameter int OW   = conv55_pkg::OW
)(
    input  logic                clk,
    input  logic                rst,
    conv55_mac_sched_if.slave   bus
);
    localparam int IW = $clog2(TAPS);
    localparam logic [AW-1:0] SAT_LIM = AW'((64'd1 << OW) - 64'd1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_sum;
    logic [PW-1:0]   prod;
    logic [DW-1:0]   taps [TAPS];
    logic            last;
    logic            sat;
    logic            kernel_ok;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic            out_sat;
    logic            kload_ready;
    logic            pix_ready;
    logic            kload_fire;
    logic            pix_fire;

    conv55_mul8u u_mul (
        .a (bus.pix_data),
        .b (taps[idx]),
        .p (prod)
    );

    assign last       = (idx == IW'(TAPS - 1));
    assign acc_sum    = acc + AW'(prod);
    assign sat        = (acc_sum > SAT_LIM);
    assign kload_fire = bus.kload_valid & kload_ready;
    assign pix_fire   = bus.pix_valid & pix_ready;

    always_comb begin
        kload_ready = 1'b0;
        pix_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                kload_ready = 1'b1;
                pix_ready   = kernel_ok & ~bus.kload_valid;
            end
            KLOAD: kload_ready = 1'b1;
            ACC:   pix_ready   = 1'b1;
            default: ;
        endcase
    end

    // Tap storage is intentionally not reset; kernel_ok guards its use.
    always_ff @(posedge clk) begin
        if (!rst && kload_fire)
            taps[idx] <= bus.kload_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            kernel_ok <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (kload_fire) begin
                        kernel_ok <= 1'b0;
                        idx       <= IW'(1);
                        state     <= KLOAD;
                    end else if (pix_fire) begin
                        acc   <= AW'(prod);
                        idx   <= IW'(1);
                        state <= ACC;
                    end
                end
                KLOAD: begin
                    if (kload_fire) begin
                        if (last) begin
                            kernel_ok <= 1'b1;
                            idx       <= '0;
                            state     <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                ACC: begin
                    if (pix_fire) begin
                        acc <= acc_sum;
                        if (last) begin
                            out_data  <= sat ? OW'(SAT_LIM) : acc_sum[OW-1:0];
                            out_sat   <= sat;
                            out_valid <= 1'b1;
                            idx       <= '0;
                            state     <= OUT;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.kload_ready = kload_ready;
    assign bus.pix_ready   = pix_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_sat     = out_sat;
    assign bus.kernel_ok   = kernel_ok;
endmodule

// File: tb/tb_conv55_mac_sched.sv
// Directed and randomized checks of conv55_mac_sched against a sum-of-products model.
module tb_conv55_mac_sched;
    typedef logic [7:0] win_t [25];

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    conv55_mac_sched_if #(.DW(8), .OW(18)) bus ();

    conv55_mac_sched #(.TAPS(25), .DW(8), .OW(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_sum(input win_t k, input win_t p);
        int s = 0;
        for (int i = 0; i < 25; i++) s += int'(k[i]) * int'(p[i]);
        return s;
    endfunction

    task automatic beat_k(input logic [7:0] d);
        logic ok;
        int   n = 0;
        bus.kload_valid = 1'b1;
        bus.kload_data  = d;
        do begin
            @(negedge clk);
            ok = bus.kload_ready;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("kload_timeout", 0, 1);
        bus.kload_valid = 1'b0;
    endtask

    task automatic beat_p(input logic [7:0] d, output logic last_ov);
        logic ok;
        int   n = 0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        do begin
            @(negedge clk);
            ok      = bus.pix_ready;
            last_ov = bus.out_valid;
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("pix_timeout", 0, 1);
        bus.pix_valid = 1'b0;
    endtask

    task automatic load_kernel(input win_t k);
        for (int i = 0; i < 25; i++) beat_k(k[i]);
        @(negedge clk);
        chk("kernel_ok_after_load", bus.kernel_ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_window(input string tag, input win_t k, input win_t p,
                              input int gaps, input int hold);
        int          s;
        logic [17:0] exp_d;
        logic        exp_s;
        logic        ov;
        s     = model_sum(k, p);
        exp_s = (s > 262143);
        exp_d = exp_s ? 18'd262143 : 18'(s);
        for (int i = 0; i < 25; i++) begin
            if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            beat_p(p[i], ov);
        end
        chk({tag, "_ov_before"}, ov, 0);
        bus.out_ready = (hold == 0);
        @(negedge clk);
        chk({tag, "_ov_latency"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, exp_d);
        chk({tag, "_sat"}, bus.out_sat, exp_s);
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_hold_ov"}, bus.out_valid, 1);
            chk({tag, "_hold_data"}, bus.out_data, exp_d);
            chk({tag, "_hold_rdy"}, {bus.pix_ready, bus.kload_ready}, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_clear"}, bus.out_valid, 0);
        chk({tag, "_idle_krdy"}, bus.kload_ready, 1);
        @(posedge clk); #1;
    endtask

    win_t k, p;
    logic ov;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst             = 1'b1;
        bus.kload_valid = 1'b0;
        bus.kload_data  = '0;
        bus.pix_valid   = 1'b0;
        bus.pix_data    = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_kernel_ok", bus.kernel_ok, 0);
        chk("rst_kload_ready", bus.kload_ready, 1);
        chk("rst_pix_ready", bus.pix_ready, 0);
        @(posedge clk); #1;

        foreach (k[i]) k[i] = 8'd1;
        foreach (p[i]) p[i] = 8'd1;
        load_kernel(k);
        run_window("ones", k, p, 0, 0);

        foreach (k[i]) k[i] = 8'(i);
        foreach (p[i]) p[i] = 8'd2;
        load_kernel(k);
        run_window("ramp_x2", k, p, 0, 0);
        foreach (p[i]) p[i] = 8'd1;
        run_window("ramp_x1", k, p, 0, 0);

        foreach (k[i]) k[i] = 8'd255;
        foreach (p[i]) p[i] = 8'd255;
        load_kernel(k);
        run_window("sat", k, p, 0, 0);

        foreach (p[i]) p[i] = 8'($urandom_range(0, 255));
        run_window("hold10", k, p, 0, 10);

        bus.kload_valid = 1'b1;
        bus.kload_data  = 8'd7;
        bus.pix_valid   = 1'b1;
        bus.pix_data    = 8'd9;
        @(negedge clk);
        chk("prio_pix_ready", bus.pix_ready, 0);
        chk("prio_kload_ready", bus.kload_ready, 1);
        @(posedge clk); #1;
        bus.kload_valid = 1'b0;
        bus.pix_valid   = 1'b0;
        @(negedge clk);
        chk("prio_kernel_ok", bus.kernel_ok, 0);
        @(posedge clk); #1;
        k[0] = 8'd7;
        for (int i = 1; i < 25; i++) begin
            k[i] = 8'($urandom_range(0, 255));
            beat_k(k[i]);
        end
        @(negedge clk);
        chk("prio_reload_ok", bus.kernel_ok, 1);
        @(posedge clk); #1;
        foreach (p[i]) p[i] = 8'($urandom_range(0, 255));
        run_window("prio_win", k, p, 0, 0);

        for (int w = 0; w < 6; w++) begin
            if (w % 2 == 0) begin
                foreach (k[i]) k[i] = 8'($urandom_range(0, 255));
                load_kernel(k);
            end
            foreach (p[i]) p[i] = 8'($urandom_range(0, 255));
            run_window("rand", k, p, 1, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 12; i++) beat_p(8'($urandom_range(0, 255)), ov);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.pix_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_out_sat", bus.out_sat, 0);
        chk("mid_rst_kernel_ok", bus.kernel_ok, 0);
        chk("mid_rst_kload_ready", bus.kload_ready, 1);
        chk("mid_rst_pix_ready", bus.pix_ready, 0);
        begin
            int bad = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (bus.out_valid !== 1'b0 || bus.pix_ready !== 1'b0) bad++;
            end
            chk("mid_rst_quiet", bad, 0);
        end
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;

        foreach (k[i]) k[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++) beat_k(k[i]);
        @(negedge clk);
        chk("partial_kernel_ok", bus.kernel_ok, 0);
        chk("partial_pix_ready", bus.pix_ready, 0);
        @(posedge clk); #1;
        for (int i = 10; i < 25; i++) beat_k(k[i]);
        @(negedge clk);
        chk("full_kernel_ok", bus.kernel_ok, 1);
        @(posedge clk); #1;
        foreach (p[i]) p[i] = 8'($urandom_range(0, 255));
        run_window("after_rst", k, p, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
